output_tensor_writer: RTL and testbench

- Sits directly downstream of the systolic-array output path.
- Consumes the streaming int8 result (valid/value/row/col/index), computes the byte address in the output activation tensor (NHWC: channel fastest), buffers entries in a small FIFO to absorb write-port backpressure, and coalesces bytes for the same 32-bit word.
- Issues word writes with byte enables to the activation RAM over a valid/ready handshake.

---
 rtl/output_tensor_writer_if.sv | 40 ++++
 rtl/output_tensor_writer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_output_tensor_writer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_tensor_writer_if.sv
// -----------------------------------------------------------------------------
// output_tensor_writer_if
//   Word-write port from the output tensor writer to the activation RAM.
//   Valid/ready handshake: a write transfers on a clock edge where both
//   wr_valid and wr_ready are high.
//
//   Signals:
//     wr_valid  writer -> RAM   write request valid
//     wr_ready  RAM -> writer   RAM accepts the write
//     wr_addr   writer -> RAM   word address (ADDR_BITS-2 bits)
//     wr_data   writer -> RAM   write data, little-endian byte lanes
//     wr_be     writer -> RAM   byte enables, one per lane
//
//   Modports: master = writer side, slave = RAM side.
// -----------------------------------------------------------------------------
interface output_tensor_writer_if #(
    parameter int ADDR_BITS = 16
) ();
    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_BITS-3:0]   wr_addr;
    logic [31:0]            wr_data;
    logic [3:0]             wr_be;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output wr_be,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  wr_be,
        output wr_ready
    );
endinterface

// File: rtl/output_tensor_writer.sv
// -----------------------------------------------------------------------------
// output_tensor_writer
//   Takes the int8 result stream from the systolic array, turns each value
//   into a byte address in the NHWC output tensor (channel fastest), queues
//   it in a small FIFO and coalesces consecutive bytes of the same 32-bit
//   word into a single write with byte enables.
//
//   Pipeline: S1 (address) -> FIFO -> merge register M -> write port.
//
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     bypass_maxpool    1 = address is base_addr + in_index
//     out_width         output feature-map width in pixels
//     num_channels      channels per output pixel
//     channel_idx       channel currently being produced
//     base_addr         byte base address of the output tensor
//     in_valid/in_data/in_row/in_col/in_index   result stream (no backpressure)
//     flush             pulse: emit a partial word once the pipeline drains
//     wr_if             word-write port (master modport)
//     overflow          sticky: an entry was dropped because the FIFO was full
//     idle              S1, FIFO and M empty and no flush pending
// -----------------------------------------------------------------------------
module output_tensor_writer #(
    parameter int MAX_N           = 64,
    parameter int MAX_NUM_CH      = 64,
    parameter int BYPASS_IDX_BITS = 6,
    parameter int ADDR_BITS       = 16,
    parameter int FIFO_DEPTH      = 8,
    localparam int N_BITS         = $clog2(MAX_N),
    localparam int CH_BITS        = $clog2(MAX_NUM_CH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bypass_maxpool,
    input  logic [N_BITS-1:0]           out_width,
    input  logic [CH_BITS-1:0]          num_channels,
    input  logic [CH_BITS-1:0]          channel_idx,
    input  logic [ADDR_BITS-1:0]        base_addr,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    input  logic [N_BITS-1:0]           in_row,
    input  logic [N_BITS-1:0]           in_col,
    input  logic [BYPASS_IDX_BITS-1:0]  in_index,
    input  logic                        flush,
    output_tensor_writer_if.master      wr_if,
    output logic                        overflow,
    output logic                        idle
);

    localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
    localparam int PROD_W    = 2 * N_BITS + CH_BITS + 2;
    localparam int WORD_BITS = ADDR_BITS - 2;
    localparam logic [PTR_BITS:0] DEPTH_CNT = (PTR_BITS + 1)'(FIFO_DEPTH);

    // One-hot byte enable for a lane.
    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        logic [3:0] oh;
        case (lane)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Place a byte in its lane of a 32-bit word, other lanes zero.
    function automatic logic [31:0] lane_data(input logic [1:0] lane, input logic [7:0] value);
        logic [31:0] w;
        case (lane)
            2'd0:    w = {24'h000000, value};
            2'd1:    w = {16'h0000, value, 8'h00};
            2'd2:    w = {8'h00, value, 16'h0000};
            2'd3:    w = {value, 24'h000000};
            default: w = 32'h00000000;
        endcase
        return w;
    endfunction

    // ---------------- state ----------------
    logic                   s1_valid_r;
    logic [ADDR_BITS-1:0]   s1_addr_r;
    logic [7:0]             s1_data_r;

    logic [ADDR_BITS-1:0]   fifo_addr_r [FIFO_DEPTH];
    logic [7:0]             fifo_data_r [FIFO_DEPTH];
    logic [PTR_BITS:0]      wr_ptr_r;
    logic [PTR_BITS:0]      rd_ptr_r;

    logic                   m_valid_r;
    logic [WORD_BITS-1:0]   m_word_r;
    logic [31:0]            m_data_r;
    logic [3:0]             m_be_r;

    logic                   flush_pending_r;
    logic                   emit_hold_r;
    logic                   overflow_r;

    // ---------------- combinational ----------------
    logic [PROD_W-1:0]      pixel_s;
    logic [PROD_W-1:0]      lin_s;
    logic [ADDR_BITS-1:0]   byte_addr_s;

    logic [PTR_BITS:0]      fifo_count_s;
    logic [PTR_BITS:0]      fifo_count_next_s;
    logic                   fifo_empty_s;
    logic                   fifo_full_s;
    logic [ADDR_BITS-1:0]   head_addr_s;
    logic [7:0]             head_data_s;
    logic [WORD_BITS-1:0]   head_word_s;
    logic [1:0]             head_lane_s;
    logic                   word_match_s;
    logic                   lane_hit_s;

    logic                   emit_cond_s;
    logic                   wr_valid_s;
    logic                   xfer_s;
    logic                   m_free_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   drop_s;
    logic                   m_valid_next_s;
    logic                   all_empty_next_s;
    logic                   flush_pending_next_s;

    // Byte address of the incoming value; computed wide, then wrapped to ADDR_BITS.
    always_comb begin
        pixel_s = PROD_W'(in_row) * PROD_W'(out_width) + PROD_W'(in_col);
        lin_s   = pixel_s * PROD_W'(num_channels) + PROD_W'(channel_idx);
        if (bypass_maxpool) begin
            byte_addr_s = base_addr + ADDR_BITS'(in_index);
        end else begin
            byte_addr_s = base_addr + ADDR_BITS'(lin_s);
        end
    end

    // FIFO status and head-of-queue decode against the merge register.
    always_comb begin
        fifo_count_s = wr_ptr_r - rd_ptr_r;
        fifo_empty_s = (fifo_count_s == '0);
        fifo_full_s  = (fifo_count_s == DEPTH_CNT);
        head_addr_s  = fifo_addr_r[rd_ptr_r[PTR_BITS-1:0]];
        head_data_s  = fifo_data_r[rd_ptr_r[PTR_BITS-1:0]];
        head_word_s  = head_addr_s[ADDR_BITS-1:2];
        head_lane_s  = head_addr_s[1:0];
        word_match_s = (head_word_s == m_word_r);
        lane_hit_s   = m_be_r[head_lane_s];
    end

    // Emit / pop / push decisions for the current cycle.
    always_comb begin
        emit_cond_s = (m_be_r == 4'b1111)
                   || (!fifo_empty_s && (!word_match_s || lane_hit_s))
                   || (flush_pending_r && !s1_valid_r && fifo_empty_s);
        // Once offered, a write stays offered until it transfers, even if new
        // arrivals would otherwise make the emit condition false.
        wr_valid_s  = m_valid_r && (emit_cond_s || emit_hold_r);
        xfer_s      = wr_valid_s && wr_if.wr_ready;
        m_free_s    = !m_valid_r || xfer_s;
        pop_s       = !fifo_empty_s
                   && (m_free_s || (word_match_s && !lane_hit_s && !wr_valid_s));
        push_s      = s1_valid_r && (!fifo_full_s || pop_s);
        drop_s      = s1_valid_r && fifo_full_s && !pop_s;
        m_valid_next_s = pop_s || (m_valid_r && !xfer_s);

        if (push_s && !pop_s) begin
            fifo_count_next_s = fifo_count_s + (PTR_BITS + 1)'(1);
        end else if (pop_s && !push_s) begin
            fifo_count_next_s = fifo_count_s - (PTR_BITS + 1)'(1);
        end else begin
            fifo_count_next_s = fifo_count_s;
        end

        // Flush is satisfied on the edge that leaves the whole pipeline empty.
        all_empty_next_s     = !in_valid && (fifo_count_next_s == '0) && !m_valid_next_s;
        flush_pending_next_s = (flush_pending_r || flush) && !all_empty_next_s;
    end

    // Address stage S1.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= '0;
            s1_data_r  <= 8'h00;
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_addr_r <= byte_addr_s;
                s1_data_r <= in_data;
            end
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r[PTR_BITS-1:0]] <= s1_addr_r;
            fifo_data_r[wr_ptr_r[PTR_BITS-1:0]] <= s1_data_r;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (PTR_BITS + 1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_BITS + 1)'(1);
            end
        end
    end

    // Merge register: load a fresh word, merge a byte into it, or retire it.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_r <= 1'b0;
            m_word_r  <= '0;
            m_data_r  <= 32'h00000000;
            m_be_r    <= 4'b0000;
        end else if (pop_s) begin
            m_valid_r <= 1'b1;
            if (m_free_s) begin
                m_word_r <= head_word_s;
                m_be_r   <= lane_onehot(head_lane_s);
                m_data_r <= lane_data(head_lane_s, head_data_s);
            end else begin
                m_be_r   <= m_be_r | lane_onehot(head_lane_s);
                m_data_r <= m_data_r | lane_data(head_lane_s, head_data_s);
            end
        end else if (xfer_s) begin
            // Keep the address; clear lanes so an idle port shows no stale data.
            m_valid_r <= 1'b0;
            m_data_r  <= 32'h00000000;
            m_be_r    <= 4'b0000;
        end
    end

    // Control flags: flush request, held write offer, sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_pending_r <= 1'b0;
            emit_hold_r     <= 1'b0;
            overflow_r      <= 1'b0;
        end else begin
            flush_pending_r <= flush_pending_next_s;
            emit_hold_r     <= wr_valid_s && !wr_if.wr_ready;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign wr_if.wr_valid = wr_valid_s;
    assign wr_if.wr_addr  = m_word_r;
    assign wr_if.wr_data  = m_data_r;
    assign wr_if.wr_be    = m_be_r;
    assign overflow       = overflow_r;
    assign idle           = !s1_valid_r && fifo_empty_s && !m_valid_r && !flush_pending_r;

endmodule

// File: tb/tb_output_tensor_writer.sv
// -----------------------------------------------------------------------------
// tb_output_tensor_writer
//   Directed bench for output_tensor_writer: reset state, single value with
//   flush, four-lane coalescing, backpressure, bypass addressing with wrap,
//   FIFO overflow with back-to-back drain, and reset during a held write.
// -----------------------------------------------------------------------------
module tb_output_tensor_writer;

    logic        clk;
    logic        reset;
    logic        bypass_maxpool;
    logic [5:0]  out_width;
    logic [6:0]  num_channels;
    logic [6:0]  channel_idx;
    logic [15:0] base_addr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [5:0]  in_row;
    logic [5:0]  in_col;
    logic [5:0]  in_index;
    logic        flush;
    logic        overflow;
    logic        idle;

    int n_tests;
    int n_fail;

    output_tensor_writer_if #(.ADDR_BITS(16)) wr_bus ();

    output_tensor_writer #(
        .MAX_N(64), .MAX_NUM_CH(64), .BYPASS_IDX_BITS(6), .ADDR_BITS(16), .FIFO_DEPTH(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bypass_maxpool (bypass_maxpool),
        .out_width      (out_width),
        .num_channels   (num_channels),
        .channel_idx    (channel_idx),
        .base_addr      (base_addr),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_row         (in_row),
        .in_col         (in_col),
        .in_index       (in_index),
        .flush          (flush),
        .wr_if          (wr_bus),
        .overflow       (overflow),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] row, input logic [5:0] col,
                         input logic [5:0] idx, input logic [7:0] value);
        in_row   = row;
        in_col   = col;
        in_index = idx;
        in_data  = value;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Waits (bounded) for a transfer and returns what was written.
    task automatic wait_write(input int limit, output logic found,
                              output logic [13:0] addr, output logic [31:0] data,
                              output logic [3:0] be, output int waited);
        found  = 1'b0;
        addr   = 14'h0;
        data   = 32'h0;
        be     = 4'h0;
        waited = 0;
        for (int i = 0; i < limit && !found; i++) begin
            if (wr_bus.wr_valid && wr_bus.wr_ready) begin
                found = 1'b1;
                addr  = wr_bus.wr_addr;
                data  = wr_bus.wr_data;
                be    = wr_bus.wr_be;
            end else begin
                waited++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_tests++; if (wr_bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid got %0b want 0", wr_bus.wr_valid); end
        n_tests++; if (wr_bus.wr_addr !== 14'h0) begin n_fail++; $display("FAIL reset_wr_addr got %h want 0", wr_bus.wr_addr); end
        n_tests++; if (wr_bus.wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data got %h want 0", wr_bus.wr_data); end
        n_tests++; if (wr_bus.wr_be !== 4'h0) begin n_fail++; $display("FAIL reset_wr_be got %b want 0000", wr_bus.wr_be); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %0b want 1", idle); end
    endtask

    task automatic test_single();
        logic found; logic [13:0] a; logic [31:0] d; logic [3:0] be; int w;
        wr_bus.wr_ready = 1'b1;
        bypass_maxpool = 1'b0; out_width = 6'd8; num_channels = 7'd4;
        channel_idx = 7'd2; base_addr = 16'h0;
        drive(6'd1, 6'd3, 6'd0, 8'h5A);
        pulse_flush();
        wait_write(20, found, a, d, be, w);
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL single_found got %0b want 1", found); end
        n_tests++; if (a !== 14'd11) begin n_fail++; $display("FAIL single_addr got %0d want 11", a); end
        n_tests++; if (be !== 4'b0100) begin n_fail++; $display("FAIL single_be got %b want 0100", be); end
        n_tests++; if (d !== 32'h005A0000) begin n_fail++; $display("FAIL single_data got %h want 005a0000", d); end
        tick();
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle got %0b want 1", idle); end
    endtask

    task automatic test_coalesce();
        logic found; logic [13:0] a; logic [31:0] d; logic [3:0] be; int w;
        logic [7:0] vals [4];
        int extra;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        wr_bus.wr_ready = 1'b1;
        out_width = 6'd8; num_channels = 7'd4; base_addr = 16'h0;
        for (int c = 0; c < 4; c++) begin
            channel_idx = 7'(c);
            drive(6'd0, 6'd0, 6'd0, vals[c]);
        end
        wait_write(20, found, a, d, be, w);
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL coalesce_found got %0b want 1", found); end
        n_tests++; if (a !== 14'd0) begin n_fail++; $display("FAIL coalesce_addr got %0d want 0", a); end
        n_tests++; if (be !== 4'b1111) begin n_fail++; $display("FAIL coalesce_be got %b want 1111", be); end
        n_tests++; if (d !== 32'h44332211) begin n_fail++; $display("FAIL coalesce_data got %h want 44332211", d); end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (wr_bus.wr_valid === 1'b1) extra++;
            tick();
        end
        n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL coalesce_extra got %0d cycles valid want 0", extra); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL coalesce_idle got %0b want 1", idle); end
    endtask

    task automatic test_backpressure();
        logic found; logic [13:0] a; logic [31:0] d; logic [3:0] be; int w;
        int unstable;
        logic [7:0] b;
        wr_bus.wr_ready = 1'b0;
        out_width = 6'd8; num_channels = 7'd4; channel_idx = 7'd0; base_addr = 16'h0;
        for (int c = 0; c < 4; c++) begin
            b = 8'hA1 + 8'(c);
            drive(6'd0, 6'(c), 6'd0, b);
        end
        pulse_flush();
        unstable = 0;
        for (int i = 0; i < 15; i++) begin
            if (wr_bus.wr_valid !== 1'b1 || wr_bus.wr_addr !== 14'd0 ||
                wr_bus.wr_data !== 32'h000000A1 || wr_bus.wr_be !== 4'b0001) unstable++;
            tick();
        end
        n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_hold got %0d unstable cycles want 0", unstable); end
        wr_bus.wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b = 8'hA1 + 8'(k);
            wait_write(20, found, a, d, be, w);
            n_tests++;
            if (found !== 1'b1 || a !== 14'(k) || d !== {24'h0, b} || be !== 4'b0001) begin
                n_fail++;
                $display("FAIL bp_write%0d got found=%0b addr=%0d data=%h be=%b want addr=%0d data=%h be=0001",
                         k, found, a, d, be, k, {24'h0, b});
            end
        end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_overflow got %0b want 0", overflow); end
        tick();
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL bp_idle got %0b want 1", idle); end
    endtask

    task automatic test_bypass();
        logic found; logic [13:0] a; logic [31:0] d; logic [3:0] be; int w;
        wr_bus.wr_ready = 1'b1;
        bypass_maxpool = 1'b1; base_addr = 16'h0100;
        drive(6'd0, 6'd0, 6'd5, 8'h80);
        pulse_flush();
        wait_write(20, found, a, d, be, w);
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL bypass_found got %0b want 1", found); end
        n_tests++; if (a !== 14'h41) begin n_fail++; $display("FAIL bypass_addr got %h want 41", a); end
        n_tests++; if (be !== 4'b0010) begin n_fail++; $display("FAIL bypass_be got %b want 0010", be); end
        n_tests++; if (d !== 32'h00008000) begin n_fail++; $display("FAIL bypass_data got %h want 00008000", d); end
        // 0xFFFF + 3 wraps to byte 0x0002: word 0, lane 2.
        base_addr = 16'hFFFF;
        drive(6'd0, 6'd0, 6'd3, 8'h7E);
        pulse_flush();
        wait_write(20, found, a, d, be, w);
        n_tests++;
        if (found !== 1'b1 || a !== 14'h0 || be !== 4'b0100 || d !== 32'h007E0000) begin
            n_fail++;
            $display("FAIL bypass_wrap got found=%0b addr=%h be=%b data=%h want addr=0 be=0100 data=007e0000",
                     found, a, be, d);
        end
        bypass_maxpool = 1'b0; base_addr = 16'h0;
        tick();
    endtask

    task automatic test_overflow();
        logic found; logic [13:0] a; logic [31:0] d; logic [3:0] be; int w;
        int gaps;
        int extra;
        logic [7:0] b;
        wr_bus.wr_ready = 1'b0;
        out_width = 6'd16; num_channels = 7'd4; channel_idx = 7'd0; base_addr = 16'h0;
        for (int c = 0; c < 12; c++) begin
            b = 8'h10 + 8'(c);
            drive(6'd0, 6'(c), 6'd0, b);
        end
        pulse_flush();
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0b want 1", overflow); end
        for (int i = 0; i < 5; i++) tick();
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
        wr_bus.wr_ready = 1'b1;
        gaps = 0;
        for (int k = 0; k < 9; k++) begin
            b = 8'h10 + 8'(k);
            wait_write(30, found, a, d, be, w);
            if (k > 0 && w != 0) gaps++;
            n_tests++;
            if (found !== 1'b1 || a !== 14'(k) || d !== {24'h0, b} || be !== 4'b0001) begin
                n_fail++;
                $display("FAIL ovf_write%0d got found=%0b addr=%0d data=%h be=%b want addr=%0d data=%h be=0001",
                         k, found, a, d, be, k, {24'h0, b});
            end
        end
        n_tests++; if (gaps !== 0) begin n_fail++; $display("FAIL ovf_back_to_back got %0d gaps want 0", gaps); end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_bus.wr_valid === 1'b1) extra++;
            tick();
        end
        n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL ovf_extra_writes got %0d want 0", extra); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL ovf_idle got %0b want 1", idle); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_still_set got %0b want 1", overflow); end
    endtask

    task automatic test_reset_mid();
        logic found; logic [13:0] a; logic [31:0] d; logic [3:0] be; int w;
        logic seen;
        wr_bus.wr_ready = 1'b0;
        out_width = 6'd8; num_channels = 7'd4; channel_idx = 7'd1; base_addr = 16'h0;
        drive(6'd2, 6'd2, 6'd0, 8'h33);
        pulse_flush();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (wr_bus.wr_valid === 1'b1) seen = 1'b1;
            else tick();
        end
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_before got %0b want 1", seen); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (wr_bus.wr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr_valid got %0b want 0", wr_bus.wr_valid); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle got %0b want 1", idle); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow got %0b want 0", overflow); end
        wr_bus.wr_ready = 1'b1;
        // (0*8+1)*4+1 = 5: word 1, lane 1.
        drive(6'd0, 6'd1, 6'd0, 8'h5C);
        pulse_flush();
        wait_write(20, found, a, d, be, w);
        n_tests++;
        if (found !== 1'b1 || a !== 14'd1 || be !== 4'b0010 || d !== 32'h00005C00) begin
            n_fail++;
            $display("FAIL rstmid_next got found=%0b addr=%0d be=%b data=%h want addr=1 be=0010 data=00005c00",
                     found, a, be, d);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; bypass_maxpool = 1'b0; out_width = 6'd0; num_channels = 7'd0;
        channel_idx = 7'd0; base_addr = 16'h0; in_valid = 1'b0; in_data = 8'h0;
        in_row = 6'd0; in_col = 6'd0; in_index = 6'd0; flush = 1'b0;
        wr_bus.wr_ready = 1'b1;
        test_reset();
        test_single();
        test_coalesce();
        test_backpressure();
        test_bypass();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
